pipelined_normalisation: RTL and testbench
==========================================

PIPELINED_NORMALISATION -- requirements
Module: pipelined_normalisation

Interface
REQ-001 Parameter MANT_W, default 24: mantissa width including hidden bit; product width P = 2*MANT_W; legal range 8..64.
REQ-002 Parameter TAG_W, default 4: width of the sideband tag carried alongside each product.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 inValid  input  1  upstream product valid.
REQ-006 inReady  output  1  block can accept a product this cycle.
REQ-007 multiplicationResult  input  P  unsigned mantissa product.
REQ-008 sign  input  1  product sign, used only by directed rounding.
REQ-009 roundMode  input  2  0 = RNE, 1 = RTZ, 2 = RUP (toward +inf), 3 = RDN (toward -inf); sampled with the product.
REQ-010 inTag  input  TAG_W  sideband, returned unchanged.
REQ-011 outValid  output  1  result valid.
REQ-012 outReady  input  1  downstream accepts result.
REQ-013 normalisedResult  output  MANT_W  rounded, normalised mantissa.
REQ-014 exponentInc  output  2  exponent adjustment, 0..2.
REQ-015 outTag  output  TAG_W  tag of the current result.

Function
REQ-016 Transfer occurs on a rising edge with valid and ready both high, on each side.
REQ-017 Pipeline has two register stages: S1 (align and GRS extraction) and S2 (round and renormalise); latency is exactly 2 cycles from input transfer to outValid with no stall; throughput is 1 per cycle.
REQ-018 S1 alignment when in[P-1] = 1: mant = in[P-1:MANT_W], guard = in[MANT_W-1], sticky = OR of in[MANT_W-2:0], base increment = 1.
REQ-019 S1 alignment when in[P-1] = 0: mant = in[P-2:MANT_W-1], guard = in[MANT_W-2], sticky = OR of in[MANT_W-3:0], base increment = 0.
REQ-020 Round-up decision (L = mant LSB): RNE rounds up when G&(S|L); RTZ never rounds up; RUP rounds up when ~sign&(G|S); RDN rounds up when sign&(G|S).
REQ-021 Rounding is an MANT_W+1-bit add; on carry out, normalisedResult = {1, zeros} and exponentInc = base increment + 1; otherwise normalisedResult = sum[MANT_W-1:0] and exponentInc = base increment.
REQ-022 An all-zero product gives normalisedResult = 0 and exponentInc = 0 in every mode.
REQ-023 Ready chain: s2Ready = ~s2Valid | outReady; s1Ready = ~s1Valid | s2Ready; inReady = s1Ready (combinational path allowed).
REQ-024 While outValid & ~outReady, normalisedResult, exponentInc and outTag are held stable, and outValid does not drop.
REQ-025 On a simultaneous output transfer and input transfer with a full pipeline, data advances with no bubble and none is lost.
REQ-026 roundMode and sign travel with their product; a change to either between transfers does not affect products already in flight.

Reset
REQ-027 rst_n low at a clock edge clears both stage valid flags; outValid = 0, normalisedResult = 0, exponentInc = 0, outTag = 0.
REQ-028 Reset mid-operation discards in-flight products with no output transfer.
REQ-029 inReady = 1 in the first cycle after rst_n returns high.

Configuration
REQ-030 Macro NORM_INEXACT_EN defined: adds output port inexact (1 bit) = G|S of the result, aligned and held with normalisedResult, reset to 0.
REQ-031 Macro NORM_INEXACT_EN undefined: the port and its pipeline register are absent; all other behaviour is identical.

Structure
REQ-032 Package norm_pkg holds the roundMode encodings (RNE, RTZ, RUP, RDN), the MANT_W default and the exponentInc width constant.
REQ-033 Stage-2 rounding logic is sub-module norm_round_stage; it is combinational and parametrised by MANT_W.

Verification (MANT_W = 24)
REQ-034 0x800000_000000, RNE -> 0x800000 / inc 1, inexact 0.
REQ-035 0x7FFFFF_FFFFFF, RNE -> carry out, 0x800000 / inc 1; same input in RTZ -> 0xFFFFFF / inc 0.
REQ-036 Tie cases in RNE: 0x400000_400000 -> 0x800000 / inc 0 (even, no round-up, inexact 1); 0x400000_C00000 -> 0x800002 / inc 0; 0x400000_C00000 in RTZ -> 0x800001.
REQ-037 0x400000_000001 with sign = 0: RUP -> 0x800001; RDN -> 0x800000; with sign = 1: RDN -> 0x800001.
REQ-038 Back-to-back stream of 8 tagged products with outReady = 0 for cycles 3-6 -> no loss or reorder, outputs stable while stalled, inReady falls once both stages are full.
REQ-039 rst_n asserted with 2 products in flight -> next cycle outValid = 0, and neither product ever appears at the output.

Source files
------------

// File: rtl/norm_pkg.sv
// Shared constants for the pipelined normalisation block.
// Holds the roundMode encodings, the default mantissa width and the
// width of the exponent adjustment output.
package norm_pkg;

  localparam logic [1:0] RM_RNE = 2'd0;  // round to nearest, ties to even
  localparam logic [1:0] RM_RTZ = 2'd1;  // round toward zero
  localparam logic [1:0] RM_RUP = 2'd2;  // round toward +inf
  localparam logic [1:0] RM_RDN = 2'd3;  // round toward -inf

  localparam int MANT_W_DEFAULT = 24;
  localparam int EXP_INC_W      = 2;

endpackage

// File: rtl/norm_round_stage.sv
// Combinational round-and-renormalise step.
// Adds the round-up bit to the aligned mantissa. A carry out of the
// mantissa means the value became a power of two, so the mantissa
// collapses to the hidden bit alone and the exponent moves up by one more.
module norm_round_stage
  import norm_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEFAULT
) (
  input  logic [MANT_W-1:0]    mant,
  input  logic                 guard,
  input  logic                 sticky,
  input  logic                 baseInc,
  input  logic                 sign,
  input  logic [1:0]           roundMode,
  output logic [MANT_W-1:0]    roundedMant,
  output logic [EXP_INC_W-1:0] expInc
);

  // Round-up decision for each directed/nearest mode.
  function automatic logic roundUp(input logic [1:0] mode, input logic lsb,
                                   input logic g, input logic s, input logic sgn);
    logic up;
    case (mode)
      RM_RNE:  up = g & (s | lsb);
      RM_RTZ:  up = 1'b0;
      RM_RUP:  up = ~sgn & (g | s);
      default: up = sgn & (g | s);
    endcase
    return up;
  endfunction

  logic [MANT_W:0] sum;

  // Increment the mantissa and fold a carry back into the exponent.
  always_comb begin
    sum = {1'b0, mant} + {{MANT_W{1'b0}}, roundUp(roundMode, mant[0], guard, sticky, sign)};
    if (sum[MANT_W]) begin
      roundedMant = {1'b1, {(MANT_W-1){1'b0}}};
      expInc      = EXP_INC_W'(baseInc) + EXP_INC_W'(1);
    end else begin
      roundedMant = sum[MANT_W-1:0];
      expInc      = EXP_INC_W'(baseInc);
    end
  end

endmodule

// File: rtl/pipelined_normalisation.sv
// Two-stage normaliser for a 2*MANT_W mantissa product.
// Stage 1 aligns the product on its leading bit and extracts guard and
// sticky; stage 2 rounds and renormalises. Valid/ready handshake on both
// sides, one result per cycle, with a back-pressure chain that lets a full
// pipeline advance in the same cycle the output drains.
// Optional build macro NORM_INEXACT_EN adds an 'inexact' output flag.
module pipelined_normalisation
  import norm_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEFAULT,
  parameter int TAG_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic [2*MANT_W-1:0]    multiplicationResult,
  input  logic                   sign,
  input  logic [1:0]             roundMode,
  input  logic [TAG_W-1:0]       inTag,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [MANT_W-1:0]      normalisedResult,
  output logic [EXP_INC_W-1:0]   exponentInc,
  output logic [TAG_W-1:0]       outTag
`ifdef NORM_INEXACT_EN
  ,
  output logic                   inexact
`endif
);

  localparam int P = 2 * MANT_W;

  logic [MANT_W-1:0] alignMant;
  logic              alignGuard;
  logic              alignSticky;
  logic              alignInc;

  logic              vld_p1;
  logic [MANT_W-1:0] mant_p1;
  logic              guard_p1;
  logic              sticky_p1;
  logic              baseInc_p1;
  logic              sign_p1;
  logic [1:0]        mode_p1;
  logic [TAG_W-1:0]  tag_p1;

  logic                 vld_p2;
  logic [MANT_W-1:0]    result_p2;
  logic [EXP_INC_W-1:0] inc_p2;
  logic [TAG_W-1:0]     tag_p2;

  logic [MANT_W-1:0]    roundedMant;
  logic [EXP_INC_W-1:0] roundedInc;

  logic s1Ready;
  logic s2Ready;

  // A stage can take new data when empty or when its contents leave this cycle.
  assign s2Ready = ~vld_p2 | outReady;
  assign s1Ready = ~vld_p1 | s2Ready;
  assign inReady = s1Ready;

  // Align on the product's top bit: a set MSB means the product is in [2,4).
  always_comb begin
    if (multiplicationResult[P-1]) begin
      alignMant   = multiplicationResult[P-1:MANT_W];
      alignGuard  = multiplicationResult[MANT_W-1];
      alignSticky = |multiplicationResult[MANT_W-2:0];
      alignInc    = 1'b1;
    end else begin
      alignMant   = multiplicationResult[P-2:MANT_W-1];
      alignGuard  = multiplicationResult[MANT_W-2];
      alignSticky = |multiplicationResult[MANT_W-3:0];
      alignInc    = 1'b0;
    end
  end

  // ---- stage 1 boundary: aligned mantissa, GRS, mode and sign ----
  // Stage 1 occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n)       vld_p1 <= 1'b0;
    else if (s1Ready) vld_p1 <= inValid;
  end

  // Stage 1 payload; mode and sign are captured with their product.
  always_ff @(posedge clk) begin
    if (inValid && s1Ready) begin
      mant_p1    <= alignMant;
      guard_p1   <= alignGuard;
      sticky_p1  <= alignSticky;
      baseInc_p1 <= alignInc;
      sign_p1    <= sign;
      mode_p1    <= roundMode;
      tag_p1     <= inTag;
    end
  end

  norm_round_stage #(.MANT_W(MANT_W)) uRound (
    .mant        (mant_p1),
    .guard       (guard_p1),
    .sticky      (sticky_p1),
    .baseInc     (baseInc_p1),
    .sign        (sign_p1),
    .roundMode   (mode_p1),
    .roundedMant (roundedMant),
    .expInc      (roundedInc)
  );

  // ---- stage 2 boundary: rounded result held until downstream accepts ----
  // Output register; payload only loads when the slot frees, so a stall holds it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p2    <= 1'b0;
      result_p2 <= '0;
      inc_p2    <= '0;
      tag_p2    <= '0;
    end else begin
      if (s2Ready) vld_p2 <= vld_p1;
      if (vld_p1 && s2Ready) begin
        result_p2 <= roundedMant;
        inc_p2    <= roundedInc;
        tag_p2    <= tag_p1;
      end
    end
  end

`ifdef NORM_INEXACT_EN
  logic inexact_p2;

  // Inexact flag follows the same load/hold rule as the result.
  always_ff @(posedge clk) begin
    if (!rst_n)                 inexact_p2 <= 1'b0;
    else if (vld_p1 && s2Ready) inexact_p2 <= guard_p1 | sticky_p1;
  end

  assign inexact = inexact_p2;
`endif

  assign outValid         = vld_p2;
  assign normalisedResult = result_p2;
  assign exponentInc      = inc_p2;
  assign outTag           = tag_p2;

endmodule

// File: tb/tb_pipelined_normalisation.sv
// Directed bench for pipelined_normalisation at MANT_W = 24.
// Build with NORM_INEXACT_EN defined to also check the inexact flag.
module tb_pipelined_normalisation;

  localparam int MANT_W = 24;
  localparam int TAG_W  = 4;
  localparam int NV     = 15;

  logic                clk;
  logic                rst_n;
  logic                inValid;
  logic                inReady;
  logic [2*MANT_W-1:0] multiplicationResult;
  logic                sign;
  logic [1:0]          roundMode;
  logic [TAG_W-1:0]    inTag;
  logic                outValid;
  logic                outReady;
  logic [MANT_W-1:0]   normalisedResult;
  logic [1:0]          exponentInc;
  logic [TAG_W-1:0]    outTag;
`ifdef NORM_INEXACT_EN
  logic                inexact;
`endif

  int checks = 0;
  int errors = 0;

  logic [47:0] vProd [NV];
  logic [1:0]  vMode [NV];
  logic        vSign [NV];
  logic [23:0] vMant [NV];
  logic [1:0]  vInc  [NV];
`ifdef NORM_INEXACT_EN
  logic        vInx  [NV];
`endif

  pipelined_normalisation #(.MANT_W(MANT_W), .TAG_W(TAG_W)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .inValid              (inValid),
    .inReady              (inReady),
    .multiplicationResult (multiplicationResult),
    .sign                 (sign),
    .roundMode            (roundMode),
    .inTag                (inTag),
    .outValid             (outValid),
    .outReady             (outReady),
    .normalisedResult     (normalisedResult),
    .exponentInc          (exponentInc),
    .outTag               (outTag)
`ifdef NORM_INEXACT_EN
    ,
    .inexact              (inexact)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic driveVec(input int idx, input logic [TAG_W-1:0] tg);
    inValid              = 1'b1;
    multiplicationResult = vProd[idx];
    roundMode            = vMode[idx];
    sign                 = vSign[idx];
    inTag                = tg;
  endtask

  // One isolated transfer: checks latency of exactly two cycles and the result.
  task automatic runOne(input int idx);
    logic [TAG_W-1:0] tg;
    tg = TAG_W'(idx) ^ 4'hA;
    outReady = 1'b1;
    driveVec(idx, tg);
    #1;
    check($sformatf("v%0d inReady", idx), 64'(inReady), 64'd1);
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    #1;
    check($sformatf("v%0d early", idx), 64'(outValid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check($sformatf("v%0d outValid", idx), 64'(outValid), 64'd1);
    check($sformatf("v%0d mant", idx), 64'(normalisedResult), 64'(vMant[idx]));
    check($sformatf("v%0d inc", idx), 64'(exponentInc), 64'(vInc[idx]));
    check($sformatf("v%0d tag", idx), 64'(outTag), 64'(tg));
`ifdef NORM_INEXACT_EN
    check($sformatf("v%0d inexact", idx), 64'(inexact), 64'(vInx[idx]));
`endif
  endtask

  // Eight back-to-back products with the output stalled in cycles 3..6.
  task automatic runStream();
    int sent = 0;
    int rcvd = 0;
    logic holdPrev = 1'b0;
    logic sawFull = 1'b0;
    logic [MANT_W-1:0] heldMant = '0;
    logic [1:0]        heldInc = '0;
    logic [TAG_W-1:0]  heldTag = '0;
    inValid = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 40 && rcvd < 8; c++) begin
      outReady = !(c >= 3 && c <= 6);
      if (sent < 8) driveVec(sent, TAG_W'(sent));
      else inValid = 1'b0;
      #1;
      if (holdPrev) begin
        check("stall valid", 64'(outValid), 64'd1);
        check("stall mant", 64'(normalisedResult), 64'(heldMant));
        check("stall inc", 64'(exponentInc), 64'(heldInc));
        check("stall tag", 64'(outTag), 64'(heldTag));
      end
      if (outValid && outReady) begin
        check($sformatf("s%0d tag", rcvd), 64'(outTag), 64'(rcvd));
        check($sformatf("s%0d mant", rcvd), 64'(normalisedResult), 64'(vMant[rcvd]));
        check($sformatf("s%0d inc", rcvd), 64'(exponentInc), 64'(vInc[rcvd]));
        rcvd++;
      end
      if (!inReady) sawFull = 1'b1;
      holdPrev = outValid && !outReady;
      heldMant = normalisedResult;
      heldInc  = exponentInc;
      heldTag  = outTag;
      if (inValid && inReady) sent++;
      @(posedge clk);
      @(negedge clk);
    end
    inValid = 1'b0;
    check("stream count", 64'(rcvd), 64'd8);
    check("stream backpressure", 64'(sawFull), 64'd1);
  endtask

  // Reset with two products in flight; neither may ever emerge.
  task automatic runResetFlight();
    logic ghost = 1'b0;
    outReady = 1'b0;
    driveVec(0, 4'h3);
    @(posedge clk);
    @(negedge clk);
    driveVec(11, 4'h5);
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    #1;
    check("flight full", 64'(outValid), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("flight rst valid", 64'(outValid), 64'd0);
    check("flight rst mant", 64'(normalisedResult), 64'd0);
    check("flight rst tag", 64'(outTag), 64'd0);
    rst_n = 1'b1;
    outReady = 1'b1;
    #1;
    check("flight rst ready", 64'(inReady), 64'd1);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      if (outValid) ghost = 1'b1;
    end
    check("flight ghost", 64'(ghost), 64'd0);
  endtask

  initial begin
    vProd = '{48'h800000_000000, 48'h7FFFFF_FFFFFF, 48'h7FFFFF_FFFFFF, 48'h400000_400000,
              48'h400000_C00000, 48'h400000_C00000, 48'h400000_000001, 48'h400000_000001,
              48'h400000_000001, 48'h000000_000000, 48'h000000_000000, 48'hFFFFFF_FFFFFF,
              48'hC00000_800000, 48'hC00001_800000, 48'h400000_000001};
    vMode = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3,
              2'd3, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd2};
    vSign = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vMant = '{24'h800000, 24'h800000, 24'hFFFFFF, 24'h800000, 24'h800002, 24'h800001,
              24'h800001, 24'h800000, 24'h800001, 24'h000000, 24'h000000, 24'h800000,
              24'hC00000, 24'hC00002, 24'h800000};
    vInc  = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
              2'd0, 2'd0, 2'd0, 2'd2, 2'd1, 2'd1, 2'd0};
`ifdef NORM_INEXACT_EN
    vInx  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
              1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`endif

    rst_n = 1'b0;
    inValid = 1'b0;
    outReady = 1'b1;
    multiplicationResult = '0;
    sign = 1'b0;
    roundMode = 2'd0;
    inTag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst outValid", 64'(outValid), 64'd0);
    check("rst mant", 64'(normalisedResult), 64'd0);
    check("rst inc", 64'(exponentInc), 64'd0);
    check("rst tag", 64'(outTag), 64'd0);
`ifdef NORM_INEXACT_EN
    check("rst inexact", 64'(inexact), 64'd0);
`endif
    rst_n = 1'b1;
    #1;
    check("rst inReady", 64'(inReady), 64'd1);

    for (int i = 0; i < NV; i++) runOne(i);
    runStream();
    runResetFlight();
    runOne(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
